// File: rtl/uart_tx_buf_pkg.sv
// uart_tx_buf_pkg: shared UART encodings (3-bit FSM states, DATA_W) and the clocks-per-bit derivation
package uart_tx_buf_pkg;
  localparam int DATA_W = 8;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  function automatic int bps_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word-fall-through synchronous FIFO, depth 2**AW.
//   clk, rst (sync, active-low), push/din write, pop read (dout shows head),
//   full, empty, count. A push while full is accepted only alongside a pop.
module uart_sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign rd    = pop & ~empty;
  assign wr    = push & (~full | rd);
  assign full  = count == (AW+1)'(2**AW);
  assign empty = count == '0;
  assign dout  = mem[rp];
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wr ? wp + AW'(1) : wp;
      rp    <= rd ? rp + AW'(1) : rp;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: queues bytes from the UART receiver and re-serialises them as 8N1 frames.
//   clk; rst (sync, active-low); rx_done (0->1 = new byte); data_in[7:0];
//   txd (idle high); tx_busy (frame on line); fifo_empty; fifo_full; overflow (sticky drop flag).
//   Define UART_TX_PARITY_EN for 8E1 frames (even parity bit after the data bits).
module uart_tx_buf
  import uart_tx_buf_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int FIFO_AW  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] data_in,
  output logic              txd,
  output logic              tx_busy,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              overflow
);
  localparam int BPS_CNT = bps_cnt(CLK_FREQ, BAUD);
  localparam int CW = $clog2(BPS_CNT + 1);
  logic rx_d, push, pop, bit_end;
  logic [2:0] state, bit_idx;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] shift, dout;
  logic [FIFO_AW:0] count;
  logic unused_count;
  assign unused_count = ^count;
  assign push    = rx_done & ~rx_d;
  assign bit_end = cnt == CW'(BPS_CNT - 1);
  // Popping at the last stop cycle chains frames with no idle gap.
  assign pop     = ~fifo_empty & (state == S_IDLE | (state == S_STOP & bit_end));
  assign tx_busy = state != S_IDLE;
  uart_sync_fifo #(.DW(DATA_W), .AW(FIFO_AW)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(data_in), .dout(dout),
    .full(fifo_full), .empty(fifo_empty), .count(count)
  );
`ifdef UART_TX_PARITY_EN
  logic par;
  assign txd = state == S_START ? 1'b0 : state == S_DATA ? shift[0] : state == S_PARITY ? par : 1'b1;
  always_ff @(posedge clk)
    if (!rst) par <= 1'b0;
    else if (pop) par <= ^dout;
`else
  assign txd = state == S_START ? 1'b0 : state == S_DATA ? shift[0] : 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_d     <= 1'b0;
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      overflow <= 1'b0;
    end else begin
      rx_d <= rx_done;
      if (push & fifo_full & ~pop) overflow <= 1'b1;
      cnt <= (state == S_IDLE || bit_end) ? '0 : cnt + CW'(1);
      if (pop) begin
        shift   <= dout;
        bit_idx <= '0;
        state   <= S_START;
      end else if (bit_end) begin
        if (state == S_START) state <= S_DATA;
        else if (state == S_DATA) begin
          shift   <= shift >> 1;
          bit_idx <= bit_idx + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_idx == 3'd7) state <= S_PARITY;
        end else if (state == S_PARITY) state <= S_STOP;
`else
          if (bit_idx == 3'd7) state <= S_STOP;
        end
`endif
        else if (state == S_STOP) state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: directed self-checking bench for uart_tx_buf at 50 MHz / 115200 baud
module tb_uart_tx_buf;
  localparam int BPS = 434;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0, rst = 1'b0, rx_done = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic txd, tx_busy, fifo_empty, fifo_full, overflow;
  int n_chk = 0, n_fail = 0;
  uart_tx_buf #(.CLK_FREQ(50_000_000), .BAUD(115200), .FIFO_AW(4)) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .data_in(data_in), .txd(txd),
    .tx_busy(tx_busy), .fifo_empty(fifo_empty), .fifo_full(fifo_full), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic recv_frame(input logic [7:0] exp, input int ofs, output int k);
    k = 0;
    do begin @(negedge clk); k++; end while (txd !== 1'b0 && k < 2*NB*BPS);
    check("start_seen", txd, 0);
    repeat (BPS/2 - ofs) @(negedge clk);
    check("start_bit", txd, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (BPS) @(negedge clk);
      check("data_bit", txd, exp[i]);
    end
`ifdef UART_TX_PARITY_EN
    repeat (BPS) @(negedge clk);
    check("parity_bit", txd, ^exp);
`endif
    repeat (BPS) @(negedge clk);
    check("stop_bit", txd, 1);
    check("busy_stop", tx_busy, 1);
    repeat (BPS - BPS/2 - 1) @(negedge clk);
    check("busy_last", tx_busy, 1);
  endtask
  task automatic pulse(input logic [7:0] d);
    rx_done = 1'b1;
    data_in = d;
    @(negedge clk);
    rx_done = 1'b0;
  endtask
  initial begin
    int k, lows;
    repeat (2) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b1;
    @(negedge clk);
    pulse(8'h55);
    check("t1_not_empty", fifo_empty, 0);
    check("t1_txd_idle", txd, 1);
    recv_frame(8'h55, 0, k);
    check("t1_latency", k, 1);
    @(negedge clk);
    check("t1_busy_end", tx_busy, 0);
    check("t1_txd_end", txd, 1);
    check("t1_empty_end", fifo_empty, 1);
    rx_done = 1'b1;
    data_in = 8'hA3;
    @(negedge clk);
    check("t2_not_empty", fifo_empty, 0);
    recv_frame(8'hA3, 0, k);
    check("t2_latency", k, 1);
    @(negedge clk);
    check("t2_busy_end", tx_busy, 0);
    check("t2_empty", fifo_empty, 1);
    repeat (700) @(negedge clk);
    check("t2_one_frame", tx_busy, 0);
    rx_done = 1'b0;
    repeat (5) @(negedge clk);
    check("t2_still_idle", tx_busy, 0);
    pulse(8'h01);
    @(negedge clk);
    pulse(8'h02);
    @(negedge clk);
    pulse(8'h03);
    recv_frame(8'h01, 4, k);
    check("t3_first", k, 1);
    recv_frame(8'h02, 0, k);
    check("t3_gap2", k, 1);
    recv_frame(8'h03, 0, k);
    check("t3_gap3", k, 1);
    @(negedge clk);
    check("t3_busy_end", tx_busy, 0);
    check("t3_empty", fifo_empty, 1);
    pulse(8'h10);
    @(negedge clk);
    check("t4_in_start", txd, 0);
    for (int i = 0; i < 17; i++) begin
      pulse(8'h20 + 8'(i));
      if (i == 15) begin
        check("t4_full16", fifo_full, 1);
        check("t4_no_ovf_yet", overflow, 0);
      end
      @(negedge clk);
    end
    check("t4_ovf", overflow, 1);
    check("t4_full", fifo_full, 1);
    repeat (20) @(negedge clk);
    check("t4_ovf_sticky", overflow, 1);
    check("t4_busy", tx_busy, 1);
    check("t4_still_start", txd, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t4_rst_ovf", overflow, 0);
    check("t4_rst_full", fifo_full, 0);
    check("t4_rst_empty", fifo_empty, 1);
    rst = 1'b1;
    @(negedge clk);
    pulse(8'hC5);
    @(negedge clk);
    check("t5_start", txd, 0);
    for (int i = 0; i < 4; i++) begin
      pulse(8'(i + 1));
      @(negedge clk);
    end
    check("t5_queued", fifo_empty, 0);
    repeat (4*BPS + 200 - 8) @(negedge clk);
    check("t5_bit3", txd, 0);
    check("t5_busy", tx_busy, 1);
    rst = 1'b0;
    @(negedge clk);
    check("t5_txd", txd, 1);
    check("t5_busy_rst", tx_busy, 0);
    check("t5_empty", fifo_empty, 1);
    check("t5_ovf", overflow, 0);
    rst = 1'b1;
    lows = 0;
    repeat (6000) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    check("t5_quiet", lows, 0);
    pulse(8'h07);
    recv_frame(8'h07, 0, k);
    check("t6_latency07", k, 1);
    @(negedge clk);
    check("t6_end07", tx_busy, 0);
    pulse(8'h03);
    recv_frame(8'h03, 0, k);
    check("t6_latency03", k, 1);
    @(negedge clk);
    check("t6_end03", tx_busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
